alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencer and two-port arbiter for the shared 16-bit Arithmetic_unit. It accepts operations from two requesters over valid/ready, arbitrates round-robin, and drives the ALU operand and op inputs. It waits out the ALU's registered latency, then sequences register-file writeback (two beats for multiply) and maintains the architectural flag register from the ALU flag outputs. It sits between decode/issue and the register file.

Parameters:
DATA_W, 16, operand/result width; must match the ALU.
REG_AW, 4, register-file address width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  4  ALU operation code
req0_a  in  DATA_W  operand 1
req0_b  in  DATA_W  operand 2
req0_dst  in  REG_AW  destination register
req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_dst  same as requester 0
alu_operation  out  4  to ALU operation
alu_op1  out  DATA_W  to ALU op1
alu_op2  out  DATA_W  to ALU op2
alu_result_low  in  DATA_W  from ALU
alu_result_high  in  DATA_W  from ALU
alu_flag_en  in  3  from ALU
alu_flag_val  in  3  from ALU
wb_en  out  1  register-file write strobe
wb_addr  out  REG_AW  write address
wb_data  out  DATA_W  write data
flags  out  3  architectural flags: [2]=carry, [1]=less, [0]=equal
done0  out  1  one-cycle pulse on requester 0's final writeback cycle
done1  out  1  one-cycle pulse on requester 1's final writeback cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; flags=3'b000; last_grant=1, so requester 0 wins first.
- Reset has priority. Asserting reset mid-operation aborts the operation: no further wb_en, no done, flags cleared.
- States: IDLE -> EXEC -> WB_LO -> (WB_HI if op==4'h2) -> IDLE.
- IDLE arbitration:
  - Exactly one req_ready is asserted combinationally, to the winner only, and only in IDLE.
  - Only one valid: grant it.
  - Both valid: grant the requester that was not last_grant.
  - On grant: latch op, a, b, dst and requester id; update last_grant; go to EXEC.
- EXEC: alu_operation/alu_op1/alu_op2 are driven from the latched values. They are held constant from EXEC through the end of the operation and are 0 in IDLE. The ALU samples them at the end of EXEC.
- WB_LO (ALU results valid):
  - wb_en=1, wb_addr=dst, wb_data=alu_result_low for every op except compare (4'hb), which has wb_en=0.
  - Flags update at the end of WB_LO, only from the ALU's defining ops.
  - op 4'h0: flags[2] <= alu_flag_val[2] if alu_flag_en[2].
  - op 4'hb: flags[1:0] <= alu_flag_val[1:0]. Bits whose alu_flag_en is 0 are cleared.
  - All other ops leave flags unchanged. The ALU's stale sticky flag outputs are ignored.
- WB_HI (multiply only): wb_en=1, wb_addr=dst+1 modulo 2^REG_AW (15 wraps to 0), wb_data=alu_result_high.
- done0/done1 pulse in the final writeback state (WB_LO, or WB_HI for multiply) of the owning requester. For compare, the pulse still occurs in WB_LO even though wb_en=0.
- Latency and throughput: accept at cycle T; WB_LO at T+2; WB_HI at T+3. Next accept is possible at T+3, or T+4 for multiply.
- Undefined op codes (4'ha, 4'hc-4'hf) are sequenced normally and write alu_result_low (0 from the ALU default path).
- Requests are never dropped: a valid not granted must stay asserted, with stable payload, until ready.

Test Plan:
- Single add: req0 op=0, a=16'hFFFF, b=16'h0001, dst=3 -> req0_ready at T. At T+2: wb_en=1, wb_addr=3, wb_data=16'h0000, done0=1. After T+2: flags[2]=1.
- Multiply with wrap: req1 op=2, a=16'h1234, b=16'h0100, dst=15 -> T+2: wb_addr=15, data=16'h3400. T+3: wb_addr=0, data=16'h0012, done1=1 at T+3 only.
- Compare equal: op=4'hb, a=b=16'h00AA -> no wb_en in any cycle. After WB_LO: flags[1:0]=2'b01, flags[2] unchanged. done pulses.
- Arbitration: both valid continuously with op=3 -> grants alternate 0,1,0,1. Each loser holds its request and is serviced within 4 cycles. Out of reset, req0 is granted first.
- Flags isolation: add sets carry, then op=4 (or) -> flags stay 3'b100 despite stale ALU flag outputs.
- Reset mid-multiply: assert reset in WB_LO -> next cycle IDLE with wb_en=0, no done, flags=0, busy=0. A new request is accepted on the following cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue sequencer and two-port round-robin arbiter in front of the shared
//   16-bit arithmetic unit. One operation is in flight at a time:
//     IDLE  -> arbitrate and latch the winning request
//     EXEC  -> drive the ALU inputs; the ALU registers them at the end of EXEC
//     WB_LO -> write the low result word (compare writes nothing), update flags
//     WB_HI -> multiply only: write the high word to dst+1
//   The architectural flag register is updated only from the op that defines
//   each flag, so stale sticky flag outputs from the ALU never leak in.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid/ready        valid/ready handshake for requester N (0, 1)
//   reqN_op/a/b/dst         operation code, operands, destination register
//   alu_operation/op1/op2   ALU inputs; 0 while idle, held for the whole op
//   alu_result_low/high     ALU registered results
//   alu_flag_en/val         ALU flag outputs (carry, less, equal)
//   wb_en/addr/data         register-file write port
//   flags                   architectural flags {carry, less, equal}
//   done0/done1             pulse on the owning requester's final writeback
//   busy                    an operation is in flight

module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [REG_AW-1:0] req0_dst,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [REG_AW-1:0] req1_dst,
  output logic [3:0]        alu_operation,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_result_low,
  input  logic [DATA_W-1:0] alu_result_high,
  input  logic [2:0]        alu_flag_en,
  input  logic [2:0]        alu_flag_val,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              done0,
  output logic              done1,
  output logic              busy
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_CMP = 4'hb;

  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [REG_AW-1:0] dst;
    logic              id;
  } issue_t;

  state_t state, state_nxt;
  issue_t cur, win;
  logic   last_grant;
  logic   grant_vld, grant_id;
  logic   fin;

  // Arbitration: only in IDLE; on contention the requester that did not
  // win last time gets the slot.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld & ~grant_id;
  assign req1_ready = grant_vld &  grant_id;

  always_comb begin
    if (grant_id) win = '{op: req1_op, a: req1_a, b: req1_b, dst: req1_dst, id: 1'b1};
    else          win = '{op: req0_op, a: req0_a, b: req0_b, dst: req0_dst, id: 1'b0};
  end

  // Next state and writeback sequencing
  always_comb begin
    state_nxt = state;
    wb_en     = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    fin       = 1'b0;
    case (state)
      IDLE: if (grant_vld) state_nxt = EXEC;
      EXEC: state_nxt = WB_LO;
      WB_LO: begin
        if (cur.op != OP_CMP) begin
          wb_en   = 1'b1;
          wb_addr = cur.dst;
          wb_data = alu_result_low;
        end
        if (cur.op == OP_MUL) state_nxt = WB_HI;
        else begin
          state_nxt = IDLE;
          fin       = 1'b1;
        end
      end
      WB_HI: begin
        wb_en     = 1'b1;
        wb_addr   = cur.dst + REG_AW'(1);   // 15 wraps to 0
        wb_data   = alu_result_high;
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done0 = fin & ~cur.id;
  assign done1 = fin &  cur.id;
  assign busy  = (state != IDLE);

  // ALU inputs come from the latched request and are held until the op ends.
  assign alu_operation = busy ? cur.op : '0;
  assign alu_op1       = busy ? cur.a  : '0;
  assign alu_op2       = busy ? cur.b  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      last_grant <= 1'b1;
      flags      <= 3'b000;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        cur        <= win;
        last_grant <= grant_id;
      end
      // Results (and flag outputs) belonging to this op are valid in WB_LO.
      if (state == WB_LO) begin
        case (cur.op)
          OP_ADD: if (alu_flag_en[2]) flags[2] <= alu_flag_val[2];
          OP_CMP: flags[1:0] <= alu_flag_en[1:0] & alu_flag_val[1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int NC     = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_dst, req1_dst;
  logic [3:0]  alu_operation;
  logic [15:0] alu_op1, alu_op2, alu_result_low, alu_result_high;
  logic [2:0]  alu_flag_en, alu_flag_val;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  flags;
  logic        done0, done1, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_dst(req0_dst),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_dst(req1_dst),
    .alu_operation(alu_operation), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result_low(alu_result_low), .alu_result_high(alu_result_high),
    .alu_flag_en(alu_flag_en), .alu_flag_val(alu_flag_val),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flags(flags),
    .done0(done0), .done1(done1), .busy(busy)
  );

  // ---------------- ALU stand-in: one registered stage, sticky flags --------
  logic [1:0] cmp_en = 2'b11;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h0: alu_fn = {16'h0, a + b};
      4'h1: alu_fn = {16'h0, a - b};
      4'h2: alu_fn = 32'(a) * 32'(b);
      4'h3: alu_fn = {16'h0, a & b};
      4'h4: alu_fn = {16'h0, a | b};
      4'h5: alu_fn = {16'h0, a ^ b};
      4'h6: alu_fn = {16'h0, ~a};
      4'h7: alu_fn = {16'h0, a >> 1};
      4'h8: alu_fn = {16'h0, a << 1};
      4'h9: alu_fn = {16'h0, b};
      default: alu_fn = 32'h0;
    endcase
  endfunction

  function automatic logic carry_fn(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_low  <= '0;
      alu_result_high <= '0;
      alu_flag_en     <= '0;
      alu_flag_val    <= '0;
    end else begin
      {alu_result_high, alu_result_low} <= alu_fn(alu_operation, alu_op1, alu_op2);
      if (alu_operation == 4'h0) begin
        alu_flag_en[2]  <= 1'b1;
        alu_flag_val[2] <= carry_fn(alu_op1, alu_op2);
      end
      if (alu_operation == 4'hb) begin
        alu_flag_en[1:0]  <= cmp_en;
        alu_flag_val[1:0] <= {alu_op1 < alu_op2, alu_op1 == alu_op2};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] dst);
    if (!id) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_dst = dst;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_dst = dst;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic [3:0]  dst;
    logic [1:0]  cmpen;
    logic [15:0] lo, hi;
    logic [2:0]  fl;      // flags expected once the op has finished
  } vec_t;

  vec_t tbl [10];

  task automatic run_row(input vec_t v);
    logic       mul, cmp;
    logic [3:0] d1;
    mul = (v.op == 4'h2);
    cmp = (v.op == 4'hb);
    d1  = v.dst + 4'd1;
    cmp_en = v.cmpen;
    drive(v.id, 1'b1, v.op, v.a, v.b, v.dst);
    @(negedge clk);
    chk("row_ready", {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
    tick();
    drive(v.id, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    chk("row_exec", {busy, wb_en, alu_operation, alu_op1, alu_op2}, {1'b1, 1'b0, v.op, v.a, v.b});
    tick();
    @(negedge clk);
    if (cmp) chk("row_wb_lo", {wb_en, wb_addr, wb_data}, '0);
    else     chk("row_wb_lo", {wb_en, wb_addr, wb_data}, {1'b1, v.dst, v.lo});
    chk("row_done_lo", {done1, done0}, mul ? 2'b00 : (v.id ? 2'b10 : 2'b01));
    tick();
    if (mul) begin
      @(negedge clk);
      chk("row_wb_hi", {wb_en, wb_addr, wb_data}, {1'b1, d1, v.hi});
      chk("row_done_hi", {done1, done0}, v.id ? 2'b10 : 2'b01);
      tick();
    end
    @(negedge clk);
    chk("row_after", {busy, wb_en, done1, done0, flags}, {4'b0000, v.fl});
    tick();
  endtask

  // ---------------- random phase reference model ----------------
  typedef struct packed {
    logic        r0, r1, wen;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        d0, d1, bsy;
    logic [3:0]  aop;
    logic [15:0] a1, a2;
  } exp_t;

  exp_t ex [NC+8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [3:0]  op_list [8];
    logic        pend [2];
    logic [3:0]  pop [2];
    logic [15:0] pa [2];
    logic [15:0] pb [2];
    logic [3:0]  pd [2];
    logic [2:0]  mflags, upd_val;
    logic [31:0] res;
    logic [3:0]  d1;
    int          mlast, free_at, upd_at, g, len, got, w;

    tbl[0] = '{1'b0, 4'h0, 16'hFFFF, 16'h0001, 4'd3,  2'b11, 16'h0000, 16'h0000, 3'b100};
    tbl[1] = '{1'b1, 4'h2, 16'h1234, 16'h0100, 4'd15, 2'b11, 16'h3400, 16'h0012, 3'b100};
    tbl[2] = '{1'b0, 4'hb, 16'h00AA, 16'h00AA, 4'd5,  2'b11, 16'h0000, 16'h0000, 3'b101};
    tbl[3] = '{1'b1, 4'h4, 16'h00F0, 16'h0F00, 4'd7,  2'b11, 16'h0FF0, 16'h0000, 3'b101};
    tbl[4] = '{1'b0, 4'h0, 16'h0001, 16'h0002, 4'd0,  2'b11, 16'h0003, 16'h0000, 3'b001};
    tbl[5] = '{1'b1, 4'hb, 16'h0001, 16'h0005, 4'd6,  2'b11, 16'h0000, 16'h0000, 3'b010};
    tbl[6] = '{1'b0, 4'ha, 16'h1234, 16'h0001, 4'd9,  2'b11, 16'h0000, 16'h0000, 3'b010};
    tbl[7] = '{1'b1, 4'h1, 16'h0005, 16'h0003, 4'd2,  2'b11, 16'h0002, 16'h0000, 3'b010};
    tbl[8] = '{1'b0, 4'hb, 16'h0001, 16'h0005, 4'd4,  2'b01, 16'h0000, 16'h0000, 3'b000};
    tbl[9] = '{1'b1, 4'h2, 16'hFFFF, 16'hFFFF, 4'd14, 2'b11, 16'h0001, 16'hFFFE, 3'b000};

    // reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    tick();
    tick();
    @(negedge clk);
    chk("reset_state", {req0_ready, req1_ready, busy, wb_en, wb_addr, wb_data, done0, done1,
                        flags, alu_operation, alu_op1, alu_op2}, '0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_row(tbl[i]);

    // arbitration: both valid continuously, grants alternate starting with 0
    reset_dut();
    drive(1'b0, 1'b1, 4'h3, 16'h00FF, 16'h0F0F, 4'd1);
    drive(1'b1, 1'b1, 4'h3, 16'hFF00, 16'h0F0F, 4'd2);
    for (int k = 0; k < 4; k++) begin
      got = -1;
      w   = 0;
      while (got < 0 && w < 8) begin
        @(negedge clk);
        if (req0_ready && req1_ready) got = 2;
        else if (req0_ready) got = 0;
        else if (req1_ready) got = 1;
        if (got < 0) begin
          tick();
          w++;
        end
      end
      chk("arb_grant", 64'(got), 64'(k % 2));
      chk("arb_wait", 64'(w), (k == 0) ? 64'd0 : 64'd2);
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    for (int k = 0; k < 4; k++) tick();

    // reset in the middle of a multiply
    reset_dut();
    drive(1'b0, 1'b1, 4'h0, 16'hFFFF, 16'h0001, 4'd1);
    tick();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("rst_pre_flags", flags, 3'b100);
    tick();
    drive(1'b1, 1'b1, 4'h2, 16'h1234, 16'h0100, 4'd8);
    @(negedge clk);
    chk("rst_mul_ready", {req1_ready, req0_ready}, 2'b10);
    tick();
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_wb_lo", {wb_en, wb_addr, wb_data}, {1'b1, 4'd8, 16'h3400});
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_abort", {busy, wb_en, done0, done1, flags}, '0);
    tick();
    drive(1'b0, 1'b1, 4'h5, 16'h00FF, 16'h0F0F, 4'd11);
    @(negedge clk);
    chk("rst_new_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    tick();
    @(negedge clk);
    chk("rst_new_wb", {wb_en, wb_addr, wb_data, done0}, {1'b1, 4'd11, 16'h0FF0, 1'b1});
    tick();

    // randomized traffic against a cycle-indexed expectation table
    op_list = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hb, 4'ha, 4'hf};
    cmp_en  = 2'b11;
    for (int i = 0; i < NC + 8; i++) ex[i] = '0;
    for (int r = 0; r < 2; r++) pend[r] = 1'b0;
    mflags  = 3'b000;
    mlast   = 1;
    free_at = 0;
    upd_at  = -1;
    upd_val = 3'b000;
    reset_dut();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0) begin
          pend[r] = 1'b1;
          pop[r]  = op_list[$urandom_range(0, 7)];
          pa[r]   = 16'($urandom);
          pb[r]   = ($urandom_range(0, 3) == 0) ? pa[r] : 16'($urandom);
          pd[r]   = 4'($urandom);
        end
        drive(r[0], pend[r], pop[r], pa[r], pb[r], pd[r]);
      end

      if (c == upd_at) mflags = upd_val;
      g = -1;
      if (c >= free_at) begin
        if (pend[0] && pend[1]) g = (mlast == 1) ? 0 : 1;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end
      if (g >= 0) begin
        len = (pop[g] == 4'h2) ? 4 : 3;
        res = alu_fn(pop[g], pa[g], pb[g]);
        d1  = pd[g] + 4'd1;
        if (g == 0) ex[c].r0 = 1'b1; else ex[c].r1 = 1'b1;
        for (int k = 1; k < len; k++) begin
          ex[c+k].bsy = 1'b1;
          ex[c+k].aop = pop[g];
          ex[c+k].a1  = pa[g];
          ex[c+k].a2  = pb[g];
        end
        if (pop[g] != 4'hb) begin
          ex[c+2].wen = 1'b1;
          ex[c+2].wa  = pd[g];
          ex[c+2].wd  = res[15:0];
        end
        if (pop[g] == 4'h2) begin
          ex[c+3].wen = 1'b1;
          ex[c+3].wa  = d1;
          ex[c+3].wd  = res[31:16];
        end
        if (g == 0) ex[c+len-1].d0 = 1'b1; else ex[c+len-1].d1 = 1'b1;
        if (pop[g] == 4'h0) begin
          upd_at  = c + 3;
          upd_val = {carry_fn(pa[g], pb[g]), mflags[1:0]};
        end
        if (pop[g] == 4'hb) begin
          upd_at  = c + 3;
          upd_val = {mflags[2], pa[g] < pb[g], pa[g] == pb[g]};
        end
        free_at = c + len;
        mlast   = g;
        pend[g] = 1'b0;
      end

      @(negedge clk);
      chk("rnd_ready", {req1_ready, req0_ready}, {ex[c].r1, ex[c].r0});
      chk("rnd_wb", {wb_en, wb_addr, wb_data}, {ex[c].wen, ex[c].wa, ex[c].wd});
      chk("rnd_done", {done1, done0}, {ex[c].d1, ex[c].d0});
      chk("rnd_status", {busy, flags}, {ex[c].bsy, mflags});
      chk("rnd_alu", {alu_operation, alu_op1, alu_op2}, {ex[c].aop, ex[c].a1, ex[c].a2});
      tick();
    end
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
